// File: rtl/lcd_bus_arbiter.sv
// LCD bus arbiter: shares one HD44780-style bus between two byte writers.
// Round-robin grant with optional lock, timed setup/pulse/hold/exec phases.
module lcd_bus_arbiter #(
    parameter int T_SETUP     = 2,
    parameter int T_PULSE     = 5,
    parameter int T_HOLD      = 2,
    parameter int T_EXEC      = 2000,
    parameter int T_EXEC_LONG = 82000,
    parameter int CW          = 17
) (
    input  logic       mclk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic [1:0] lock,
    input  logic       rs_in0,
    input  logic [7:0] db_in0,
    input  logic       rs_in1,
    input  logic [7:0] db_in1,
    output logic [1:0] gnt,
    output logic [1:0] done,
    output logic       busy,
    output logic       RS,
    output logic       E,
    output logic       RW,
    output logic [7:0] DB
);

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        PULSE,
        HOLD,
        EXEC
    } state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic          last;
    logic          own_vld;
    logic          own;
    logic          idx;
    logic          win;
    logic          cap;
    logic          long_wait;

    assign RW = 1'b0;

    assign cap = (state == IDLE) && (done == 2'b00) && (req != 2'b00);

    // clear/home commands need the long execution wait
    assign long_wait = !RS && (DB[7:2] == 6'd0);

    // pick the winner: a requesting lock owner first, then round-robin
    always_comb begin
        win = 1'b0;
        unique case (1'b1)
            (own_vld && req[own]): win = own;
            (req == 2'b01):        win = 1'b0;
            (req == 2'b10):        win = 1'b1;
            default:               win = ~last;
        endcase
    end

    // transfer sequencer with registered bus and handshake outputs
    always_ff @(posedge mclk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            cnt     <= '0;
            last    <= 1'b1;
            own_vld <= 1'b0;
            own     <= 1'b0;
            idx     <= 1'b0;
            gnt     <= 2'b00;
            done    <= 2'b00;
            busy    <= 1'b0;
            RS      <= 1'b0;
            E       <= 1'b0;
            DB      <= 8'h00;
        end else begin
            done <= 2'b00;
            unique case (state)
                IDLE: begin
                    if (cap) begin
                        if (own_vld && !req[own]) begin
                            own_vld <= 1'b0;
                        end
                        idx   <= win;
                        last  <= win;
                        gnt   <= win ? 2'b10 : 2'b01;
                        busy  <= 1'b1;
                        RS    <= win ? rs_in1 : rs_in0;
                        DB    <= win ? db_in1 : db_in0;
                        cnt   <= CW'(T_SETUP - 1);
                        state <= SETUP;
                    end
                end
                SETUP: begin
                    if (cnt == '0) begin
                        E     <= 1'b1;
                        cnt   <= CW'(T_PULSE - 1);
                        state <= PULSE;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                PULSE: begin
                    if (cnt == '0) begin
                        E     <= 1'b0;
                        cnt   <= CW'(T_HOLD - 1);
                        state <= HOLD;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                HOLD: begin
                    if (cnt == '0) begin
                        cnt   <= long_wait ? CW'(T_EXEC_LONG - 1)
                                           : CW'(T_EXEC - 1);
                        state <= EXEC;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                EXEC: begin
                    if (cnt == '0) begin
                        gnt     <= 2'b00;
                        busy    <= 1'b0;
                        done    <= idx ? 2'b10 : 2'b01;
                        own_vld <= lock[idx];
                        own     <= idx;
                        state   <= IDLE;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
